// File: rtl/sub_div_combine_4_bit.sv
// sub_div_combine_4_bit: registered wrap-around subtraction plus an iterative
// restoring divider (one quotient bit per clock) under a start/busy/done
// handshake. Unsigned WIDTH-bit operands.
//
// Optional build macro SUB_BORROW_OUT_EN: adds output sub_borrow = (a < b),
// registered alongside Result_sub.
module sub_div_combine_4_bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Result_sub,
  output logic [WIDTH-1:0] Result_quo,
  output logic [WIDTH-1:0] Result_rem
`ifdef SUB_BORROW_OUT_EN
  ,
  output logic             sub_borrow
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring step: shift the next dividend bit into the partial
  // remainder; the full remainder is kept so divisors with the MSB set work.
  always_comb begin
    trial    = {rem_q, quo_q[WIDTH-1]};
    rem_next = trial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, divisor}) begin
      rem_next = WIDTH'(trial - {1'b0, divisor});
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM, subtract result and divider datapath with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      Result_sub  <= '0;
      Result_quo  <= '0;
      Result_rem  <= '0;
      divisor     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt         <= '0;
`ifdef SUB_BORROW_OUT_EN
      sub_borrow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            divisor     <= b;
            Result_sub  <= a - b;
`ifdef SUB_BORROW_OUT_EN
            sub_borrow  <= (a < b);
`endif
            div_by_zero <= 1'b0;
            rem_q       <= '0;
            quo_q       <= a;
            cnt         <= '0;
            if (b == '0) begin
              div_by_zero <= 1'b1;
              Result_quo  <= '1;
              Result_rem  <= a;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            Result_quo <= quo_next;
            Result_rem <= rem_next;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
